// File: rtl/bus_burst_slave_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared types and helpers for the valid/ready burst bus: response codes,
// burst addressing modes, slave FSM states and the burst-legality checks.
// No ports (package).
// -----------------------------------------------------------------------------
package bus_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b01
    } resp_t;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10,
        RSVD  = 2'b11
    } burst_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DATA
    } state_t;

    // WRAP bursts must be a power-of-two number of beats, at least two.
    function automatic logic is_legal_wrap(input logic [3:0] len);
        return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    endfunction

    // True when every beat of the burst must answer SLVERR regardless of address.
    function automatic logic burst_is_illegal(input burst_t bt, input logic [3:0] len);
        return (bt == RSVD) || ((bt == WRAP) && !is_legal_wrap(len));
    endfunction

endpackage

// File: rtl/bus_burst_slave_if.sv
// -----------------------------------------------------------------------------
// bus_burst_slave_if
// Valid/ready burst bus bundle.
//   valid, wr_en, addr, wdata, burst_len, burst_type : manager -> slave
//   ready, rdata, resp                               : slave -> manager
// Modports: master (drives requests), slave (answers them).
// -----------------------------------------------------------------------------
interface bus_burst_slave_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  valid;
    logic                  ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            resp;
    logic [3:0]            burst_len;
    logic [1:0]            burst_type;

    modport master (
        output valid, wr_en, addr, wdata, burst_len, burst_type,
        input  ready, rdata, resp
    );

    modport slave (
        input  valid, wr_en, addr, wdata, burst_len, burst_type,
        output ready, rdata, resp
    );
endinterface

// File: rtl/bus_burst_slave_addr_gen.sv
// -----------------------------------------------------------------------------
// bus_addr_gen
// Purely combinational next-beat address calculator, shared with manager blocks.
//   cur_addr_i   : address of the current beat
//   burst_type_i : FIXED / INCR / WRAP / RSVD
//   burst_len_i  : beats-1
//   next_addr_o  : address of the following beat
// -----------------------------------------------------------------------------
module bus_addr_gen
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic [ADDR_WIDTH-1:0] cur_addr_i,
    input  burst_t                burst_type_i,
    input  logic [3:0]            burst_len_i,
    output logic [ADDR_WIDTH-1:0] next_addr_o
);
    logic [ADDR_WIDTH-1:0] mask;
    logic [ADDR_WIDTH-1:0] incr;

    always_comb begin
        // beats-1 doubles as the wrap mask for the legal power-of-two lengths
        mask = ADDR_WIDTH'(burst_len_i);
        incr = cur_addr_i + ADDR_WIDTH'(1);
        case (burst_type_i)
            INCR:    next_addr_o = incr;
            WRAP:    next_addr_o = (cur_addr_i & ~mask) | (incr & mask);
            default: next_addr_o = cur_addr_i;
        endcase
    end
endmodule

// File: rtl/bus_burst_slave.sv
// -----------------------------------------------------------------------------
// bus_burst_slave
// Memory-backed burst slave: FIXED/INCR/WRAP bursts of 1..16 beats, optional
// first-beat wait states, per-beat SLVERR for out-of-range or illegal bursts.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : bus_burst_slave_if.slave (valid/ready handshake, addr, data, resp)
// -----------------------------------------------------------------------------
module bus_burst_slave
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bus_burst_slave_if.slave      bus
);
    localparam int                  MEM_AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(MEM_DEPTH);
    localparam logic [3:0]          WAIT_LAST = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic                  wr_q, wr_d;
    logic [3:0]            len_q, len_d;
    burst_t                type_q, type_d;
    logic [3:0]            beat_cnt_q, beat_cnt_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic                  ready_q, ready_d;
    resp_t                 resp_q, resp_d;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  burst_bad, cur_err, next_err;
    logic                  rd_load, rd_clear, rd_err, mem_we;
    logic [MEM_AW-1:0]     rd_idx;

    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} >= DEPTH_LIM;
    endfunction

    bus_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
        .cur_addr_i   (cur_addr_q),
        .burst_type_i (type_q),
        .burst_len_i  (len_q),
        .next_addr_o  (next_addr)
    );

    assign burst_bad = burst_is_illegal(type_q, len_q);
    assign cur_err   = burst_bad || out_of_range(cur_addr_q);
    assign next_err  = burst_bad || out_of_range(next_addr);

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        wr_d       = wr_q;
        len_d      = len_q;
        type_d     = type_q;
        beat_cnt_d = beat_cnt_q;
        wait_cnt_d = wait_cnt_q;
        ready_d    = ready_q;
        resp_d     = resp_q;
        rd_load    = 1'b0;
        rd_clear   = 1'b0;
        rd_err     = cur_err;
        rd_idx     = cur_addr_q[MEM_AW-1:0];
        mem_we     = 1'b0;
        case (state_q)
            IDLE: begin
                ready_d = 1'b0;
                resp_d  = OKAY;
                if (bus.valid) begin
                    cur_addr_d = bus.addr;
                    wr_d       = bus.wr_en;
                    len_d      = bus.burst_len;
                    type_d     = burst_t'(bus.burst_type);
                    beat_cnt_d = 4'd0;
                    wait_cnt_d = 4'd0;
                    if (WAIT_STATES > 0) state_d = WAIT;
                    else                 state_d = DATA;
                end
            end
            WAIT: begin
                if (wait_cnt_q == WAIT_LAST) state_d    = DATA;
                else                         wait_cnt_d = wait_cnt_q + 4'd1;
            end
            DATA: begin
                if (!ready_q) begin
                    // First DATA cycle is the memory read of beat 0; ready
                    // rises together with its data on the next edge.
                    ready_d = 1'b1;
                    rd_load = 1'b1;
                    if (cur_err) resp_d = SLVERR;
                    else         resp_d = OKAY;
                end else if (bus.valid) begin
                    mem_we = wr_q && (resp_q == OKAY);
                    if (beat_cnt_q == len_q) begin
                        state_d  = IDLE;
                        ready_d  = 1'b0;
                        resp_d   = OKAY;
                        rd_clear = 1'b1;
                    end else begin
                        // Prefetch the next beat at the handshake edge so
                        // back-to-back beats need no bubble.
                        beat_cnt_d = beat_cnt_q + 4'd1;
                        cur_addr_d = next_addr;
                        rd_load    = 1'b1;
                        rd_err     = next_err;
                        rd_idx     = next_addr[MEM_AW-1:0];
                        if (next_err) resp_d = SLVERR;
                        else          resp_d = OKAY;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            wr_q       <= 1'b0;
            len_q      <= 4'd0;
            type_q     <= FIXED;
            beat_cnt_q <= 4'd0;
            wait_cnt_q <= 4'd0;
            ready_q    <= 1'b0;
            resp_q     <= OKAY;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            wr_q       <= wr_d;
            len_q      <= len_d;
            type_q     <= type_d;
            beat_cnt_q <= beat_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            ready_q    <= ready_d;
            resp_q     <= resp_d;
        end
    end

    // Registered read port; data is forced to zero on write bursts and errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (rd_clear) begin
            rdata_q <= '0;
        end else if (rd_load) begin
            if (!wr_q && !rd_err) rdata_q <= mem[rd_idx];
            else                  rdata_q <= '0;
        end
    end

    // mem_we is qualified by ready_q, which reset clears, so an abort stops writes.
    always_ff @(posedge clk) begin
        if (mem_we) mem[cur_addr_q[MEM_AW-1:0]] <= bus.wdata;
    end

    assign bus.ready = ready_q;
    assign bus.rdata = rdata_q;
    assign bus.resp  = resp_q;
endmodule

// File: tb/tb_bus_burst_slave.sv
// -----------------------------------------------------------------------------
// tb_bus_burst_slave
// Two slave instances share one stimulus driver: u0 with no wait states and
// u1 with three. Expected beats are queued when a burst is issued and popped
// on each handshake.
// -----------------------------------------------------------------------------
module tb_bus_burst_slave;
    import bus_pkg::*;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          sel;
    logic          m_valid, m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [3:0]    m_len;
    logic [1:0]    m_type;
    logic          s_ready;
    logic [DW-1:0] s_rdata;
    logic [1:0]    s_resp;

    bus_burst_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if0 ();
    bus_burst_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();

    assign if0.valid      = m_valid & ~sel;
    assign if0.wr_en      = m_wr;
    assign if0.addr       = m_addr;
    assign if0.wdata      = m_wdata;
    assign if0.burst_len  = m_len;
    assign if0.burst_type = m_type;
    assign if1.valid      = m_valid & sel;
    assign if1.wr_en      = m_wr;
    assign if1.addr       = m_addr;
    assign if1.wdata      = m_wdata;
    assign if1.burst_len  = m_len;
    assign if1.burst_type = m_type;

    assign s_ready = sel ? if1.ready : if0.ready;
    assign s_rdata = sel ? if1.rdata : if0.rdata;
    assign s_resp  = sel ? if1.resp  : if0.resp;

    bus_burst_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .WAIT_STATES(0))
        u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    bus_burst_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .WAIT_STATES(3))
        u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    typedef struct {
        logic [7:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } beat_t;

    beat_t       sb_q[$];
    logic [31:0] model [2][DEPTH];
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_addr(input logic [7:0] a, input logic [3:0] len,
                                            input logic [1:0] bt, input int i);
        int beats = int'(len) + 1;
        int off;
        logic [7:0] base;
        case (bt)
            2'd1: return a + 8'(i);
            2'd2: begin
                off  = int'(a) % beats;
                base = a - 8'(off);
                return base + 8'((off + i) % beats);
            end
            default: return a;
        endcase
    endfunction

    function automatic bit exp_err(input logic [7:0] a, input logic [3:0] len, input logic [1:0] bt);
        bit wrap_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
        return (bt == 2'd3) || ((bt == 2'd2) && !wrap_ok) || (int'(a) >= DEPTH);
    endfunction

    // Called at a falling edge. exp_lat < 0 skips the latency check; stall_at
    // drops valid for two cycles at that beat; rst_at pulses reset at that beat.
    task automatic run_burst(input int d, input logic wr, input logic [7:0] a, input logic [3:0] len,
                             input logic [1:0] bt, input logic [31:0] wbase,
                             input int exp_lat, input int stall_at, input int rst_at);
        int    n = int'(len) + 1;
        int    beat = 0, edges = 0, idle = 0;
        bit    seen = 0, stalled = 0, aborted = 0, berr;
        beat_t b, e;
        logic  [1:0] di = 2'(d);
        sb_q.delete();
        for (int i = 0; i < n; i++) begin
            b.addr  = exp_addr(a, len, bt, i);
            b.wr    = wr;
            b.wdata = wbase + 32'(i);
            berr    = exp_err(b.addr, len, bt);
            b.resp  = berr ? 2'b01 : 2'b00;
            b.rdata = (wr || berr) ? 32'h0 : model[di[0]][b.addr[4:0]];
            sb_q.push_back(b);
        end
        sel     = di[0];
        m_wr    = wr;
        m_addr  = a;
        m_len   = len;
        m_type  = bt;
        m_wdata = wbase;
        m_valid = 1'b1;
        while (beat < n && !aborted) begin
            if (s_ready && m_valid) begin
                if (!seen) begin
                    seen = 1;
                    if (exp_lat >= 0) chk("latency", 32'(edges - 1), 32'(exp_lat));
                end
                if (beat == stall_at && !stalled) begin
                    stalled = 1;
                    m_valid = 1'b0;
                    repeat (2) begin
                        @(posedge clk); @(negedge clk);
                        chk("stall_ready", {31'b0, s_ready}, 32'h1);
                        chk("stall_rdata", s_rdata, sb_q[0].rdata);
                    end
                    m_valid = 1'b1;
                    continue;
                end
                if (beat == rst_at) begin
                    rst_n = 1'b0;
                    #1;
                    chk("rst_ready", {31'b0, s_ready}, 32'h0);
                    chk("rst_resp", {30'b0, s_resp}, 32'h0);
                    chk("rst_rdata", s_rdata, 32'h0);
                    chk("rst_state", 32'(di[0] ? u1.state_q : u0.state_q), 32'(IDLE));
                    aborted = 1;
                end else begin
                    e = sb_q.pop_front();
                    chk($sformatf("rdata_b%0d", beat), s_rdata, e.rdata);
                    chk($sformatf("resp_b%0d", beat), {30'b0, s_resp}, {30'b0, e.resp});
                    if (e.wr && e.resp == 2'b00) model[di[0]][e.addr[4:0]] = e.wdata;
                    @(posedge clk); @(negedge clk);
                    edges++;
                    beat++;
                    idle    = 0;
                    m_wdata = wbase + 32'(beat);
                end
            end else begin
                @(posedge clk); @(negedge clk);
                edges++;
                idle++;
                if (idle > 40) begin
                    chk("timeout_beats", 32'(beat), 32'(n));
                    aborted = 1;
                end
            end
        end
        m_valid = 1'b0;
        if (!aborted) begin
            chk("ready_after", {31'b0, s_ready}, 32'h0);
            chk("resp_after", {30'b0, s_resp}, 32'h0);
            chk("rdata_after", s_rdata, 32'h0);
        end
        if (rst_at >= 0) begin
            @(negedge clk);
            rst_n = 1'b1;
        end
        @(negedge clk);
        sb_q.delete();
        $display("burst dut=%0d wr=%0d addr=%02h len=%0d type=%0d beats_done=%0d", d, wr, a, len, bt, beat);
    endtask

    initial begin
        sel = 1'b0; m_valid = 1'b0; m_wr = 1'b0; m_addr = '0;
        m_wdata = '0; m_len = '0; m_type = '0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            sel = (d == 1);
            #1;
            chk("reset_ready", {31'b0, s_ready}, 32'h0);
            chk("reset_resp", {30'b0, s_resp}, 32'h0);
            chk("reset_rdata", s_rdata, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fill both memories so every later read has a defined value.
        for (int d = 0; d < 2; d++) begin
            run_burst(d, 1'b1, 8'h00, 4'd15, 2'd1, 32'h100 + 32'(d) * 32'h1000, -1, -1, -1);
            run_burst(d, 1'b1, 8'h10, 4'd15, 2'd1, 32'h200 + 32'(d) * 32'h1000, -1, -1, -1);
        end

        // No wait states: INCR write then read back with latency check.
        run_burst(0, 1'b1, 8'h10, 4'd3, 2'd1, 32'hA0, -1, -1, -1);
        run_burst(0, 1'b0, 8'h10, 4'd3, 2'd1, 32'h0, 1, -1, -1);
        // WRAP read crossing the 4-beat boundary.
        run_burst(0, 1'b1, 8'h0C, 4'd3, 2'd1, 32'hC, -1, -1, -1);
        run_burst(0, 1'b0, 8'h0E, 4'd3, 2'd2, 32'h0, 1, -1, -1);
        // Top of memory: second beat lands out of range.
        run_burst(0, 1'b1, 8'h1F, 4'd1, 2'd1, 32'h55, -1, -1, -1);
        run_burst(0, 1'b0, 8'h1C, 4'd3, 2'd1, 32'h0, -1, -1, -1);
        run_burst(0, 1'b0, 8'h1E, 4'd3, 2'd1, 32'h0, -1, -1, -1);
        // Illegal bursts: reserved type and 3-beat WRAP.
        run_burst(0, 1'b1, 8'h00, 4'd1, 2'd3, 32'hBAD0, -1, -1, -1);
        run_burst(0, 1'b1, 8'h00, 4'd2, 2'd2, 32'hBAD0, -1, -1, -1);
        run_burst(0, 1'b0, 8'h00, 4'd1, 2'd3, 32'h0, -1, -1, -1);
        run_burst(0, 1'b0, 8'h04, 4'd2, 2'd2, 32'h0, -1, -1, -1);
        run_burst(0, 1'b0, 8'h00, 4'd3, 2'd1, 32'h0, -1, -1, -1);
        // FIXED read repeats one word.
        run_burst(0, 1'b0, 8'h11, 4'd2, 2'd0, 32'h0, -1, -1, -1);

        // Three wait states: single-beat latency, then a stalled 4-beat read.
        run_burst(1, 1'b0, 8'h05, 4'd0, 2'd1, 32'h0, 4, -1, -1);
        run_burst(1, 1'b0, 8'h08, 4'd3, 2'd1, 32'h0, 4, 2, -1);
        run_burst(1, 1'b1, 8'h18, 4'd3, 2'd1, 32'h7700, 4, 1, -1);
        run_burst(1, 1'b0, 8'h18, 4'd3, 2'd1, 32'h0, 4, -1, -1);

        // Reset during beat 2 of a write: only beats 0-1 land.
        run_burst(0, 1'b1, 8'h04, 4'd3, 2'd1, 32'h500, -1, -1, 2);
        run_burst(0, 1'b0, 8'h04, 4'd3, 2'd1, 32'h0, 1, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d checks, expected completion", checks);
        $fatal(1, "global timeout");
    end
endmodule
